// File: rtl/pixel_unpack.sv
// pixel_unpack: unpacks 32-bit DMA words into 24-bit pixels (XRGB8888, packed RGB888, optional RGB565 via PIXEL_UNPACK_RGB565_EN)
//   ports: clk, reset (sync, active-high), i_sof/i_mode (frame start + mode latch),
//   i_data/i_valid/o_ready (word input), o_data/o_valid/i_ready (pixel output),
//   o_pixel_count (saturating pixels-since-frame-start).
module pixel_unpack #(
  parameter int CWIDTH = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_sof,
  input  logic [1:0]        i_mode,
  input  logic [31:0]       i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [23:0]       o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CWIDTH-1:0] o_pixel_count
);
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
  phase_t phase, phase_n;
  logic [1:0] mode;
  logic [23:0] res, res_n, pix;
  logic packed_mode, load_ok, hold, accept, load;
`ifdef PIXEL_UNPACK_RGB565_EN
  logic half, is565;
  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction
  assign is565 = mode == 2'd2;
  // second half of an RGB565 word is pending in res; block new input until it goes out
  assign hold = is565 & half;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    packed_mode = mode == 2'd1;
    load_ok = !o_valid | i_ready;
    o_ready = !reset & !i_sof & load_ok & (phase != P3) & !hold;
    accept = i_valid & o_ready;
    // P3 and the RGB565 upper half emit from res without consuming a word
    load = accept | (load_ok & ((phase == P3) | hold));
    phase_n = packed_mode ? phase_t'(phase + 2'd1) : P0;
    // phase stays P0 outside packed mode, so the P0 arm doubles as XRGB8888
    pix = phase == P1 ? {i_data[15:0], res[7:0]} :
          phase == P2 ? {i_data[7:0], res[15:0]} :
          phase == P3 ? res : i_data[23:0];
    res_n = phase == P0 ? {16'd0, i_data[31:24]} :
            phase == P1 ? {8'd0, i_data[31:16]} : i_data[31:8];
`ifdef PIXEL_UNPACK_RGB565_EN
    if (is565) begin
      pix = expand(half ? res[15:0] : i_data[15:0]);
      res_n = {8'd0, i_data[31:16]};
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset || i_sof) begin
      mode <= reset ? 2'd0 : i_mode;
      phase <= P0;
      res <= '0;
      o_valid <= 1'b0;
      o_pixel_count <= '0;
`ifdef PIXEL_UNPACK_RGB565_EN
      half <= 1'b0;
`endif
      if (reset) o_data <= '0;
    end else begin
      if (o_valid && i_ready && !(&o_pixel_count)) o_pixel_count <= o_pixel_count + CWIDTH'(1);
      if (accept) res <= res_n;
      if (load) begin
        o_data <= pix;
        o_valid <= 1'b1;
        phase <= phase_n;
`ifdef PIXEL_UNPACK_RGB565_EN
        half <= is565 & !half;
`endif
      end else if (i_ready) o_valid <= 1'b0;
    end
  end
endmodule
